// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants for the IF/ID stage and its hazard detector.
// No logic, no latency: constants and one pure helper function.
// Backpressure: not applicable.
package mips_pkg;

    // Opcodes the IF/ID stage needs to recognise
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LW    = 6'h23;

    // All-zero word is sll $0,$0,0, the canonical NOP
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Instruction field bit positions (LSB of each field)
    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_LSB    = 0;

    // Instructions that read rt as a source operand (lw/addi write it instead)
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the IF/ID instruction and a load in ID/EX.
// Latency: purely combinational.
// Backpressure: output hazard is the stall request; no internal state.
import mips_pkg::*;

module load_use_detect (
    input  logic       id_valid,
    input  logic [5:0] opcode,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rt,
    output logic       hazard
);

    logic rs_match;
    logic rt_match;

    // Register $0 is never a real dependency, so a load into $0 cannot stall
    always_comb begin
        rs_match = (idex_rt == rs);
        rt_match = uses_rt(opcode) && (idex_rt == rt);
        hazard   = id_valid && idex_mem_read && (idex_rt != 5'd0) && (rs_match || rt_match);
    end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with field slicing, load-use stall and flush bubble.
// Latency: 1 cycle instr_in -> instr_out; fields/hazard/pc_write are comb on held state.
// Backpressure: load-use hazard holds the register and drops pc_write; flush overrides.
// Optional hazard statistics counters are built when HAZARD_STATS_EN is defined.
import mips_pkg::*;

module if_id_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pc_plus4_in,
    input  logic [DATA_W-1:0] instr_in,
    input  logic              fetch_valid,
    input  logic              flush,
    input  logic              idex_mem_read,
    input  logic [4:0]        idex_rt,
    output logic              pc_write,
    output logic [DATA_W-1:0] instr_out,
    output logic [DATA_W-1:0] pc_plus4_out,
    output logic              id_valid,
    output logic              bubble,
    output logic [4:0]        rs_1,
    output logic [4:0]        rt_2,
    output logic [4:0]        rd_field,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic [15:0]       imm16,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic hazard;

    // Field slices feed decode directly from the latched instruction
    assign opcode   = instr_out[OPCODE_LSB +: 6];
    assign rs_1     = instr_out[RS_LSB     +: 5];
    assign rt_2     = instr_out[RT_LSB     +: 5];
    assign rd_field = instr_out[RD_LSB     +: 5];
    assign funct    = instr_out[FUNCT_LSB  +: 6];
    assign imm16    = instr_out[IMM_LSB    +: 16];

    load_use_detect u_hazard (
        .id_valid      (id_valid),
        .opcode        (opcode),
        .rs            (rs_1),
        .rt            (rt_2),
        .idex_mem_read (idex_mem_read),
        .idex_rt       (idex_rt),
        .hazard        (hazard)
    );

    // A flush redirects fetch, so the PC must advance even while a hazard is seen
    always_comb begin
        pc_write = !hazard || flush;
        bubble   = hazard || !id_valid;
    end

    // Pipeline register: reset > flush > hazard hold > load/empty
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_out    <= '0;
            pc_plus4_out <= '0;
            id_valid     <= 1'b0;
        end else if (flush) begin
            instr_out    <= '0;
            pc_plus4_out <= '0;
            id_valid     <= 1'b0;
        end else if (hazard) begin
            instr_out    <= instr_out;
            pc_plus4_out <= pc_plus4_out;
            id_valid     <= id_valid;
        end else if (fetch_valid) begin
            instr_out    <= instr_in;
            pc_plus4_out <= pc_plus4_in;
            id_valid     <= 1'b1;
        end else begin
            // Fetch gap: present a NOP but keep the last PC+4 for debug visibility
            instr_out    <= '0;
            id_valid     <= 1'b0;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating event counters; a flushed hazard cycle is not a real stall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (hazard && !flush && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed table-driven bench for if_id_stage plus hand sequences for
// field slicing and counter saturation. Counter expectations depend on
// whether HAZARD_STATS_EN is defined for the build.
module tb_if_id_stage;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [31:0]      pc_plus4_in;
    logic [31:0]      instr_in;
    logic             fetch_valid;
    logic             flush;
    logic             idex_mem_read;
    logic [4:0]       idex_rt;
    logic             pc_write;
    logic [31:0]      instr_out;
    logic [31:0]      pc_plus4_out;
    logic             id_valid;
    logic             bubble;
    logic [4:0]       rs_1;
    logic [4:0]       rt_2;
    logic [4:0]       rd_field;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [15:0]      imm16;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    if_id_stage #(.DATA_W(32), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_plus4_in   (pc_plus4_in),
        .instr_in      (instr_in),
        .fetch_valid   (fetch_valid),
        .flush         (flush),
        .idex_mem_read (idex_mem_read),
        .idex_rt       (idex_rt),
        .pc_write      (pc_write),
        .instr_out     (instr_out),
        .pc_plus4_out  (pc_plus4_out),
        .id_valid      (id_valid),
        .bubble        (bubble),
        .rs_1          (rs_1),
        .rt_2          (rt_2),
        .rd_field      (rd_field),
        .opcode        (opcode),
        .funct         (funct),
        .imm16         (imm16),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        fv;
        logic        flush;
        logic        mrd;
        logic [4:0]  irt;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        chk_pre;
        logic        e_pw;
        logic        e_bub;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_vld;
        logic [3:0]  e_stall;
        logic [3:0]  e_flush;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic r, input logic fv, input logic fl, input logic mrd,
                                input logic [4:0] irt, input logic [31:0] ins, input logic [31:0] pc,
                                input logic chk, input logic pw, input logic bub,
                                input logic [31:0] ei, input logic [31:0] ep, input logic ev,
                                input logic [3:0] es, input logic [3:0] ef);
        vec_t v;
        v.rst_n = r;   v.fv = fv;     v.flush = fl;   v.mrd = mrd;  v.irt = irt;
        v.instr = ins; v.pc = pc;     v.chk_pre = chk; v.e_pw = pw; v.e_bub = bub;
        v.e_instr = ei; v.e_pc = ep;  v.e_vld = ev;   v.e_stall = es; v.e_flush = ef;
        return v;
    endfunction

    // Counters only exist in the statistics build
    function automatic logic [3:0] stat_exp(input logic [3:0] v);
`ifdef HAZARD_STATS_EN
        return v;
`else
        return 4'd0 & v;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic fv, input logic fl, input logic mrd,
                         input logic [4:0] irt, input logic [31:0] ins, input logic [31:0] pc);
        rst_n = r; fetch_valid = fv; flush = fl; idex_mem_read = mrd;
        idex_rt = irt; instr_in = ins; pc_plus4_in = pc;
    endtask

    initial begin
        //                 rst fv fl mrd irt    instr          pc     chk pw bub  e_instr        e_pc   vld st fl
        vecs[0]  = mk(1'b0,1'b0,1'b0,1'b0,5'd0, 32'h0,        32'h0, 1'b0,1'b1,1'b1, 32'h0,        32'h0,  1'b0,4'd0,4'd0);
        vecs[1]  = mk(1'b0,1'b1,1'b0,1'b0,5'd0, 32'h12345678, 32'h4, 1'b1,1'b1,1'b1, 32'h0,        32'h0,  1'b0,4'd0,4'd0);
        vecs[2]  = mk(1'b1,1'b1,1'b0,1'b0,5'd0, 32'h012A4020, 32'h4, 1'b1,1'b1,1'b1, 32'h012A4020, 32'h4,  1'b1,4'd0,4'd0);
        vecs[3]  = mk(1'b1,1'b1,1'b0,1'b1,5'd9, 32'h8D490000, 32'h8, 1'b1,1'b0,1'b1, 32'h012A4020, 32'h4,  1'b1,4'd1,4'd0);
        vecs[4]  = mk(1'b1,1'b1,1'b0,1'b1,5'd10,32'h8D490000, 32'h8, 1'b1,1'b0,1'b1, 32'h012A4020, 32'h4,  1'b1,4'd2,4'd0);
        vecs[5]  = mk(1'b1,1'b1,1'b0,1'b0,5'd10,32'h8D490000, 32'h8, 1'b1,1'b1,1'b0, 32'h8D490000, 32'h8,  1'b1,4'd2,4'd0);
        vecs[6]  = mk(1'b1,1'b1,1'b0,1'b1,5'd9, 32'h00000020, 32'hC, 1'b1,1'b1,1'b0, 32'h00000020, 32'hC,  1'b1,4'd2,4'd0);
        vecs[7]  = mk(1'b1,1'b1,1'b0,1'b1,5'd0, 32'h02328820, 32'h10,1'b1,1'b1,1'b0, 32'h02328820, 32'h10, 1'b1,4'd2,4'd0);
        vecs[8]  = mk(1'b1,1'b1,1'b1,1'b1,5'd18,32'hAAAA0000, 32'h14,1'b1,1'b1,1'b1, 32'h0,        32'h0,  1'b0,4'd2,4'd1);
        vecs[9]  = mk(1'b1,1'b0,1'b0,1'b1,5'd0, 32'h11111111, 32'h18,1'b1,1'b1,1'b1, 32'h0,        32'h0,  1'b0,4'd2,4'd1);
        vecs[10] = mk(1'b1,1'b1,1'b0,1'b0,5'd0, 32'h012A4020, 32'h20,1'b1,1'b1,1'b1, 32'h012A4020, 32'h20, 1'b1,4'd2,4'd1);
        vecs[11] = mk(1'b1,1'b0,1'b0,1'b0,5'd0, 32'hFFFFFFFF, 32'h24,1'b1,1'b1,1'b0, 32'h0,        32'h20, 1'b0,4'd2,4'd1);
        vecs[12] = mk(1'b1,1'b1,1'b0,1'b0,5'd0, 32'h012A4020, 32'h28,1'b1,1'b1,1'b1, 32'h012A4020, 32'h28, 1'b1,4'd2,4'd1);
        vecs[13] = mk(1'b0,1'b1,1'b0,1'b1,5'd9, 32'h8D490000, 32'h2C,1'b1,1'b0,1'b1, 32'h0,        32'h0,  1'b0,4'd0,4'd0);
        vecs[14] = mk(1'b1,1'b1,1'b0,1'b1,5'd9, 32'h8D490000, 32'h2C,1'b1,1'b1,1'b1, 32'h8D490000, 32'h2C, 1'b1,4'd0,4'd0);
        vecs[15] = mk(1'b1,1'b1,1'b0,1'b1,5'd10,32'hAD2A0004, 32'h30,1'b1,1'b0,1'b1, 32'h8D490000, 32'h2C, 1'b1,4'd1,4'd0);
        vecs[16] = mk(1'b1,1'b1,1'b0,1'b0,5'd10,32'hAD2A0004, 32'h30,1'b1,1'b1,1'b0, 32'hAD2A0004, 32'h30, 1'b1,4'd1,4'd0);
        vecs[17] = mk(1'b1,1'b1,1'b0,1'b1,5'd10,32'h00000000, 32'h34,1'b1,1'b0,1'b1, 32'hAD2A0004, 32'h30, 1'b1,4'd2,4'd0);
        vecs[18] = mk(1'b1,1'b1,1'b0,1'b0,5'd10,32'h00000000, 32'h34,1'b1,1'b1,1'b0, 32'h00000000, 32'h34, 1'b1,4'd2,4'd0);

        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(vecs[i].rst_n, vecs[i].fv, vecs[i].flush, vecs[i].mrd,
                  vecs[i].irt, vecs[i].instr, vecs[i].pc);
            #1;
            if (vecs[i].chk_pre) begin
                check($sformatf("v%0d pc_write", i), {31'd0, pc_write}, {31'd0, vecs[i].e_pw});
                check($sformatf("v%0d bubble", i),   {31'd0, bubble},   {31'd0, vecs[i].e_bub});
            end
            @(posedge clk);
            #1;
            check($sformatf("v%0d instr_out", i), instr_out, vecs[i].e_instr);
            check($sformatf("v%0d pc_plus4_out", i), pc_plus4_out, vecs[i].e_pc);
            check($sformatf("v%0d id_valid", i), {31'd0, id_valid}, {31'd0, vecs[i].e_vld});
            check($sformatf("v%0d stall_cnt", i), {28'd0, stall_cnt}, {28'd0, stat_exp(vecs[i].e_stall)});
            check($sformatf("v%0d flush_cnt", i), {28'd0, flush_cnt}, {28'd0, stat_exp(vecs[i].e_flush)});
        end

        // Field slicing of add $8,$9,$10
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h012A4020, 32'h40);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h44);
        check("field rs_1",     {27'd0, rs_1},     32'd9);
        check("field rt_2",     {27'd0, rt_2},     32'd10);
        check("field rd_field", {27'd0, rd_field}, 32'd8);
        check("field opcode",   {26'd0, opcode},   32'h00);
        check("field funct",    {26'd0, funct},    32'h20);
        check("field imm16",    {16'd0, imm16},    32'h4020);
        check("field bubble",   {31'd0, bubble},   32'd0);

        // Long stall on rs: counter saturates, register holds throughout
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 32'h8D490000, 32'h44);
        for (int c = 0; c < 20; c++) begin
            #1;
            check($sformatf("sat c%0d pc_write", c), {31'd0, pc_write}, 32'd0);
            @(negedge clk);
        end
        check("sat instr_out held", instr_out, 32'h012A4020);
        check("sat pc_plus4 held", pc_plus4_out, 32'h40);
        check("sat stall_cnt", {28'd0, stall_cnt}, {28'd0, stat_exp(4'hF)});
        check("sat flush_cnt", {28'd0, flush_cnt}, {28'd0, stat_exp(4'd0)});

        // Release the stall: next instruction loads
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h8D490000, 32'h44);
        @(negedge clk);
        check("release instr_out", instr_out, 32'h8D490000);
        check("release pc_plus4", pc_plus4_out, 32'h44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
